// File: rtl/instr_fetch_if.sv
// Request/acknowledge instruction-memory port between the fetch stage (master)
// and instruction memory (slave).
interface instr_fetch_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the imem request port and the IF/ID register.
// Optional IFETCH_PERF_EN adds fetch_count / discard_count performance counters.
module instr_fetch #(
    parameter int                   PC_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter int                   INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    instr_fetch_if.master          imem,
    output logic [INSTR_WIDTH-1:0] Instr,
    output logic [PC_WIDTH-1:0]    id_pc,
    output logic                   id_valid,
    output logic                   id_flush
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [15:0]            discard_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DISCARD
    } state_e;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    req_addr_q, req_addr_d;
    logic                   req_q, req_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    id_pc_q, id_pc_d;
    logic                   id_valid_q, id_valid_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q;
    logic [PC_WIDTH-1:0]    skid_pc_q;

    logic                   fetch_load;
    logic                   skid_load;
    logic                   skid_use;
    logic                   drop_ack;
    logic [PC_WIDTH-1:0]    req_addr_inc;

    assign req_addr_inc = req_addr_q + PC_ONE;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        fetch_load = 1'b0;
        skid_load  = 1'b0;
        skid_use   = 1'b0;
        drop_ack   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (!stall) begin
                    req_addr_d = redirect ? redirect_pc : pc_q;
                    state_d    = S_REQ;
                end
            end

            S_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (imem.imem_ack) begin
                        drop_ack = 1'b1;
                        if (!stall) begin
                            req_addr_d = redirect_pc;
                            state_d    = S_REQ;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        // Outstanding request must still complete at the old address.
                        state_d = S_DISCARD;
                    end
                end else if (imem.imem_ack) begin
                    pc_d = req_addr_inc;
                    if (!stall) begin
                        fetch_load = 1'b1;
                        req_addr_d = req_addr_inc;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_IDLE;
                end else if (!stall) begin
                    skid_use   = 1'b1;
                    req_addr_d = pc_q;
                    state_d    = S_REQ;
                end
            end

            S_DISCARD: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem.imem_ack) begin
                    drop_ack = 1'b1;
                    if (!stall) begin
                        req_addr_d = redirect ? redirect_pc : pc_q;
                        state_d    = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // IF/ID: redirect flushes, stall freezes, otherwise load or insert a bubble.
        if (redirect) begin
            id_valid_d = 1'b0;
        end else if (!stall) begin
            if (fetch_load) begin
                instr_d    = imem.imem_rdata;
                id_pc_d    = req_addr_q;
                id_valid_d = 1'b1;
            end else if (skid_use) begin
                instr_d    = skid_instr_q;
                id_pc_d    = skid_pc_q;
                id_valid_d = 1'b1;
            end else begin
                id_valid_d = 1'b0;
            end
        end

        req_d = (state_d == S_REQ) || (state_d == S_DISCARD);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= '0;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
        end
    end

    // Skid contents are only meaningful in HOLD, so they need no reset.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_instr_q <= imem.imem_rdata;
            skid_pc_q    <= req_addr_q;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [15:0] discard_count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_count_q   <= '0;
            discard_count_q <= '0;
        end else begin
            if (!redirect && !stall && (fetch_load || skid_use)) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (drop_ack && (discard_count_q != 16'hFFFF)) begin
                discard_count_q <= discard_count_q + 16'd1;
            end
        end
    end

    assign fetch_count   = fetch_count_q;
    assign discard_count = discard_count_q;
`endif

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = req_addr_q;
    assign Instr          = instr_q;
    assign id_pc          = id_pc_q;
    assign id_valid       = id_valid_q;
    assign id_flush       = !id_valid_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Holds the IF/ID pipeline register whose outputs feed the decoder's Instr and flush inputs.
- Handles downstream stall, branch/jump redirect, and variable-latency memory via a one-entry skid buffer and a discard state.

Parameters:
PC_WIDTH, 16, width of PC, memory address, and id_pc
RESET_PC, 16'h0000, first fetch address after reset
INSTR_WIDTH, 16, instruction word width

Ports:
clk  input  1  single clock, rising edge
resetn  input  1  asynchronous, active-low reset
stall  input  1  downstream hazard stall; IF/ID holds
redirect  input  1  branch/jump taken; flush and refetch
redirect_pc  input  PC_WIDTH  redirect target
imem_req  output  1  instruction memory request
imem_addr  output  PC_WIDTH  request address; stable while imem_req high
imem_ack  input  1  memory response valid this cycle
imem_rdata  input  INSTR_WIDTH  instruction data, sampled only when imem_ack=1
Instr  output  INSTR_WIDTH  IF/ID instruction to decoder
id_pc  output  PC_WIDTH  PC of Instr
id_valid  output  1  IF/ID holds a real instruction
id_flush  output  1  equals !id_valid; drives decoder flush

Behaviour:
- Reset (async, resetn=0): state=IDLE, pc=RESET_PC, req_addr=RESET_PC, skid empty, Instr=0, id_pc=0, id_valid=0, imem_req=0. Reset asserted mid-request abandons the request; memory must tolerate this.
- imem_req=1 only in REQ and DISCARD. imem_addr=req_addr (registered). Once raised, req and addr stay constant until the ack cycle, regardless of stall.
- PC arithmetic: pc+1 modulo 2^PC_WIDTH (word addressed); 16'hFFFF wraps to 16'h0000.
- IDLE:
  - redirect: pc<=redirect_pc.
  - !stall: req_addr<=pc (or redirect_pc if redirect); next state REQ.
- REQ, per cycle:
  - redirect && imem_ack: drop data; pc<=redirect_pc. Go REQ with req_addr=redirect_pc if !stall, else IDLE.
  - redirect && !imem_ack: pc<=redirect_pc; go DISCARD.
  - imem_ack && !stall: Instr<=rdata, id_pc<=req_addr, id_valid<=1, pc<=req_addr+1. Back-to-back: stay REQ with req_addr<=req_addr+1, giving 1 instruction/cycle with zero-latency memory.
  - imem_ack && stall: skid<=rdata and req_addr; pc<=req_addr+1; go HOLD.
  - no ack: hold.
- HOLD (req=0):
  - redirect: drop skid; go IDLE.
  - !stall: IF/ID<=skid, id_valid<=1, req_addr<=pc; go REQ.
- DISCARD (req=1, old address):
  - redirect again: pc<=newest redirect_pc.
  - On ack: drop data; go REQ (req_addr<=pc) if !stall, else IDLE.
- IF/ID register:
  - redirect: id_valid<=0 the same edge, regardless of stall.
  - else stall: hold all fields.
  - else: loads per the state rules; otherwise id_valid<=0 (bubble).
- Latency: address to Instr is ack cycle + 1 edge.
- Redirect has priority over stall and ack; stall never drops an accepted instruction.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- When defined: output fetch_count (32-bit) increments on each edge where IF/ID loads a valid instruction; wraps at 2^32; reset to 0. Also output discard_count (16-bit, saturating) increments per dropped ack.
- When undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait memory (ack same cycle as req), stall=0 -> addresses 0000,0001,0002...; id_valid high from the 2nd edge; id_pc tracks each Instr.
- stall=1 at cycle of ack for addr 0005 -> state HOLD, imem_req=0, Instr holds 0004. Release stall -> Instr=data@0005, next req addr 0006, nothing lost or duplicated.
- 3-cycle memory latency, redirect to 0040 one cycle after req for 0010 -> imem_addr stays 0010 until ack, data dropped, next req 0040, id_valid=0 in between.
- redirect with stall=1 simultaneously -> id_valid=0 next edge, no req until stall low, then req 0040.
- RESET_PC=16'hFFFE, no stall -> addresses FFFE, FFFF, 0000.
- resetn low while imem_req high -> all outputs return to reset values immediately, asynchronously.
